// File: rtl/mmio_pkg.sv
// Shared types and helpers for the MMIO bus controller and its address decoder.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Sentinel returned by the decoder search when no slave matches the index.
  localparam int UNMAPPED = -1;

  // Width of the ack timeout counter and of the saturating error counter.
  localparam int CNT_W = 8;

  function automatic int idxw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmio_onehot_dec.sv
// Slave-index decoder: turns the address index field into a one-hot select and a mapped flag.
module mmio_onehot_dec
  import mmio_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int IDXW    = 2
) (
  input  logic [IDXW-1:0]    idx,
  output logic [NUM_SLV-1:0] onehot,
  output logic               mapped
);

  int hit;

  // Indices at or above NUM_SLV leave hit at UNMAPPED and the select all-zero.
  always_comb begin
    onehot = '0;
    hit    = UNMAPPED;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == IDXW'(i)) begin
        onehot[i] = 1'b1;
        hit       = i;
      end
    end
    mapped = (hit != UNMAPPED);
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO controller between the core data port and NUM_SLV slaves: decode, ack wait with timeout, stall.
// Defining MMIO_ERRLOG_EN adds the err_addr/err_cnt error-logging ports.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NUM_SLV = 4,
  parameter int IDX_LSB = 4,
  parameter int TMO     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DW-1:0]         wd,
  output logic [DW-1:0]         rd,
  output logic                  done,
  output logic                  err,
  output logic                  stall,
  output logic [NUM_SLV-1:0]    slv_sel,
  output logic [NUM_SLV-1:0]    slv_we,
  output logic [IDX_LSB-1:0]    slv_addr,
  output logic [DW-1:0]         slv_wd,
  input  logic [NUM_SLV-1:0]    slv_ack,
  input  logic [NUM_SLV*DW-1:0] slv_rd
`ifdef MMIO_ERRLOG_EN
  ,
  output logic [AW-1:0]         err_addr,
  output logic [CNT_W-1:0]      err_cnt
`endif
);

  localparam int IDXW = idxw(NUM_SLV);

  state_t             state;
  logic [IDXW-1:0]    dec_idx;
  logic [IDXW-1:0]    idx_q;
  logic [NUM_SLV-1:0] dec_onehot;
  logic               dec_mapped;
  logic               we_q;
  logic [CNT_W-1:0]   cnt;
  logic               addr_unused;

  assign dec_idx     = addr[IDX_LSB +: IDXW];
  assign addr_unused = ^addr[AW-1:IDX_LSB+IDXW];
  assign stall       = req && !done;

  mmio_onehot_dec #(
    .NUM_SLV(NUM_SLV),
    .IDXW   (IDXW)
  ) u_dec (
    .idx   (dec_idx),
    .onehot(dec_onehot),
    .mapped(dec_mapped)
  );

  // Selects are registered on entry to ACCESS and dropped on the same edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx_q    <= '0;
      we_q     <= 1'b0;
      cnt      <= '0;
      rd       <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      slv_sel  <= '0;
      slv_we   <= '0;
      slv_addr <= '0;
      slv_wd   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q    <= dec_idx;
            we_q     <= we;
            slv_addr <= addr[IDX_LSB-1:0];
            slv_wd   <= wd;
            if (dec_mapped) begin
              slv_sel <= dec_onehot;
              slv_we  <= dec_onehot & {NUM_SLV{we}};
              state   <= ACCESS;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          // A real ack takes priority over a timeout landing in the same cycle.
          if (slv_ack[idx_q]) begin
            if (!we_q) rd <= slv_rd[int'(idx_q)*DW +: DW];
            done    <= 1'b1;
            slv_sel <= '0;
            slv_we  <= '0;
            state   <= RESP;
          end else if (cnt == CNT_W'(TMO - 1)) begin
            done    <= 1'b1;
            err     <= 1'b1;
            slv_sel <= '0;
            slv_we  <= '0;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MMIO_ERRLOG_EN
  logic [AW-1:0] addr_q;

  // The latched address is still stable while err is high in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      if (state == IDLE && req) addr_q <= addr;
      if (err) begin
        err_addr <= addr_q;
        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl: vector table of single accesses plus hand-written corner sequences.
// Error-log checks are compiled in when MMIO_ERRLOG_EN is defined.
module tb_mmio_bus_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;
  logic          done, err, stall;
  logic [3:0]    slv_sel, slv_we, slv_ack, slv_addr;
  logic [DW-1:0] slv_wd;
  logic [4*DW-1:0] slv_rd;

  logic          req3;
  logic [AW-1:0] addr3;
  logic          done3, err3;
  logic [2:0]    slv_sel3;
  logic [DW-1:0] rd3_unused, slv_wd3_unused;
  logic          stall3_unused;
  logic [2:0]    slv_we3_unused;
  logic [3:0]    slv_addr3_unused;

`ifdef MMIO_ERRLOG_EN
  logic [AW-1:0] err_addr4_unused, err_addr3;
  logic [7:0]    err_cnt4_unused, err_cnt3;
`endif

  mmio_bus_ctrl #(.AW(AW), .DW(DW), .NUM_SLV(4), .IDX_LSB(4), .TMO(15)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd),
    .rd(rd), .done(done), .err(err), .stall(stall),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wd(slv_wd),
    .slv_ack(slv_ack), .slv_rd(slv_rd)
`ifdef MMIO_ERRLOG_EN
    , .err_addr(err_addr4_unused), .err_cnt(err_cnt4_unused)
`endif
  );

  mmio_bus_ctrl #(.AW(AW), .DW(DW), .NUM_SLV(3), .IDX_LSB(4), .TMO(15)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(1'b0), .addr(addr3), .wd(32'h0),
    .rd(rd3_unused), .done(done3), .err(err3), .stall(stall3_unused),
    .slv_sel(slv_sel3), .slv_we(slv_we3_unused), .slv_addr(slv_addr3_unused), .slv_wd(slv_wd3_unused),
    .slv_ack(3'b000), .slv_rd({3{32'h0}})
`ifdef MMIO_ERRLOG_EN
    , .err_addr(err_addr3), .err_cnt(err_cnt3)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    int          ackcyc;
    logic [3:0]  spur;
    logic [3:0]  exp_sel;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];
  vec_t v_after_rst;
  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One access: req issued at a negedge (cycle 1), outputs observed at each later negedge.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat, selcyc, bad;
    lat = 0; selcyc = 0; bad = 0;
    @(negedge clk);
    req = 1'b1; we = v.we; addr = v.addr; wd = v.wd; slv_ack = '0;
    for (int c = 2; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 2) wd = ~v.wd;
      if (done) begin
        lat = c;
      end else begin
        if (slv_sel == v.exp_sel) selcyc++;
        if (slv_we !== (v.we ? v.exp_sel : 4'b0000)) bad++;
        if (slv_wd !== v.wd) bad++;
        if (slv_addr !== v.addr[3:0]) bad++;
        if (stall !== 1'b1) bad++;
        slv_ack = (c - 1 == v.ackcyc) ? v.exp_sel : v.spur;
      end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    checkOutput({tag, "_err"}, 64'(err), 64'(v.exp_err));
    checkOutput({tag, "_rd"}, 64'(rd), 64'(v.exp_rd));
    checkOutput({tag, "_sel_cycles"}, 64'(selcyc), 64'(v.exp_lat - 2));
    checkOutput({tag, "_access_outputs_bad"}, 64'(bad), 64'd0);
    checkOutput({tag, "_sel_at_done"}, 64'(slv_sel), 64'd0);
    checkOutput({tag, "_stall_at_done"}, 64'(stall), 64'd0);
    slv_ack = '0;
    req = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    slv_rd = {32'h33333333, 32'h22222222, 32'h0000CAFE, 32'h11110000};
    //                we    addr           wd            ack spur     sel      lat err rd
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        1,  4'b0000, 4'b0010, 3,  1'b0, 32'h0000CAFE};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h5,        1,  4'b0000, 4'b0001, 3,  1'b0, 32'h0000CAFE};
    vecs[2] = '{1'b0, 32'h0000_003C, 32'h0,        4,  4'b0000, 4'b1000, 6,  1'b0, 32'h33333333};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,        0,  4'b0000, 4'b0100, 17, 1'b1, 32'h33333333};
    vecs[4] = '{1'b0, 32'h0000_0028, 32'h0,        15, 4'b0000, 4'b0100, 17, 1'b0, 32'h22222222};
    vecs[5] = '{1'b0, 32'h0000_0104, 32'hA5A5A5A5, 2,  4'b0000, 4'b0001, 4,  1'b0, 32'h11110000};
    vecs[6] = '{1'b0, 32'h0000_001C, 32'h0,        4,  4'b1101, 4'b0010, 6,  1'b0, 32'h0000CAFE};
    v_after_rst = '{1'b0, 32'h0000_0014, 32'h0,    1,  4'b0000, 4'b0010, 3,  1'b0, 32'h0000BEEF};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wd = '0; slv_ack = '0;
    req3 = 1'b0; addr3 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rd", 64'(rd), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_stall", 64'(stall), 64'd0);
    checkOutput("reset_sel", 64'(slv_sel), 64'd0);
    checkOutput("reset_we", 64'(slv_we), 64'd0);
    checkOutput("reset_addr_wd", 64'({slv_addr, slv_wd}), 64'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // req dropped after the first access cycle: access still completes
    slv_rd[63:32] = 32'h0000BEEF;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(negedge clk);
    req = 1'b0;
    checkOutput("drop_sel", 64'(slv_sel), 64'b0010);
    @(negedge clk);
    checkOutput("drop_no_early_done", 64'(done), 64'd0);
    slv_ack = 4'b0010;
    @(negedge clk);
    slv_ack = '0;
    checkOutput("drop_done", 64'({done, err}), 64'b10);
    checkOutput("drop_rd", 64'(rd), 64'h0000BEEF);

    // back-to-back: req held high, one idle cycle between accesses
    @(negedge clk);
    req = 1'b1; addr = 32'h10; slv_ack = 4'b0010;
    @(negedge clk);
    checkOutput("b2b_first_sel", 64'(slv_sel), 64'b0010);
    @(negedge clk);
    checkOutput("b2b_first_done", 64'(done), 64'd1);
    addr = 32'h30; slv_ack = 4'b1000;
    @(negedge clk);
    checkOutput("b2b_idle_gap", 64'({done, slv_sel}), 64'd0);
    @(negedge clk);
    checkOutput("b2b_second_sel", 64'(slv_sel), 64'b1000);
    @(negedge clk);
    checkOutput("b2b_second_done", 64'({done, err}), 64'b10);
    checkOutput("b2b_second_rd", 64'(rd), 64'h33333333);
    req = 1'b0; slv_ack = '0;
    @(negedge clk);

    // async reset in the middle of an access
    @(negedge clk);
    req = 1'b1; addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pre_sel", 64'(slv_sel), 64'b0100);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_sel_drop", 64'({slv_sel, done}), 64'd0);
    checkOutput("rst_rd_clear", 64'(rd), 64'd0);
    @(negedge clk);
    req = 1'b0; rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_no_done", 64'({done, err, slv_sel}), 64'd0);
    @(negedge clk);
    checkOutput("rst_no_done_later", 64'(done), 64'd0);
    applyStimulus(v_after_rst, "after_rst");

    // unmapped index on the 3-slave instance
    @(negedge clk);
    req3 = 1'b1; addr3 = 32'h30;
    @(negedge clk);
    req3 = 1'b0;
    checkOutput("unmapped_done_err", 64'({done3, err3}), 64'b11);
    checkOutput("unmapped_sel", 64'(slv_sel3), 64'd0);
    @(negedge clk);
    checkOutput("unmapped_pulse_end", 64'({done3, slv_sel3}), 64'd0);
`ifdef MMIO_ERRLOG_EN
    checkOutput("errlog_addr", 64'(err_addr3), 64'h30);
    checkOutput("errlog_cnt", 64'(err_cnt3), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
